// File: rtl/nastilite_pkg.sv
// Shared types for the NASTILite configuration-space master.
//   nasti_resp_t        - response codes carried on b_resp / r_resp
//   cfg_master_state_t  - states of the cfg master sequencer
//   C_NASTI_STRB_WIDTH  - byte-enable width for a given data width
package nastilite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } nasti_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } cfg_master_state_t;

  function automatic int C_NASTI_STRB_WIDTH(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/nastilite_if.sv
// NASTILite bundle (AW/W/B write path, AR/R read path) between the cfg master
// and the configuration-register slave.
//   master modport : drives aw_*, w_*, b_ready, ar_*, r_ready
//   slave  modport : drives aw_ready, w_ready, b_*, ar_ready, r_*
interface nastilite_if
  import nastilite_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = C_NASTI_STRB_WIDTH(DATA_WIDTH);

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/nastilite_cfg_master.sv
// Single-outstanding NASTILite master for cfg register access.
// Turns one command (read or write) into an AW+W/B or AR/R transaction and
// returns the slave's answer on the rsp stream. Only one transaction is in
// flight at a time; every output is a flop.
// Ports:
//   m_nastilite_clk / m_nastilite_aresetn : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb : command stream in
//   rsp_valid/ready/write/rdata/resp       : response stream out
//   timeout                                : sticky "no handshake progress" flag
//   m_nastilite                            : NASTILite master port
module nastilite_cfg_master
  import nastilite_pkg::*;
#(
  parameter int C_NASTI_ADDR_WIDTH = 5,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_TIMEOUT_CYCLES   = 256,
  localparam int STRB_W = C_NASTI_STRB_WIDTH(C_NASTI_DATA_WIDTH)
) (
  input  logic                          m_nastilite_clk,
  input  logic                          m_nastilite_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_NASTI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_W-1:0]             cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_NASTI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout,
  nastilite_if.master                   m_nastilite
);

  localparam int AW    = C_NASTI_ADDR_WIDTH;
  localparam int DW    = C_NASTI_DATA_WIDTH;
  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  if (!(DW == 32 || DW == 64)) begin : g_bad_data_width
    $error("nastilite_cfg_master: C_NASTI_DATA_WIDTH must be 32 or 64");
  end
  if (C_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("nastilite_cfg_master: C_TIMEOUT_CYCLES must be at least 2");
  end

  cfg_master_state_t state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_write_reg, rsp_write_next;
  logic [DW-1:0]     rsp_rdata_reg, rsp_rdata_next;
  nasti_resp_t       rsp_resp_reg, rsp_resp_next;
  logic              timeout_reg, timeout_next;
  logic              aw_valid_reg, aw_valid_next;
  logic              w_valid_reg, w_valid_next;
  logic              ar_valid_reg, ar_valid_next;
  logic              b_ready_reg, b_ready_next;
  logic              r_ready_reg, r_ready_next;
  logic [AW-1:0]     aw_addr_reg, aw_addr_next;
  logic [DW-1:0]     w_data_reg, w_data_next;
  logic [STRB_W-1:0] w_strb_reg, w_strb_next;
  logic [AW-1:0]     ar_addr_reg, ar_addr_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;

  assign aw_hs  = aw_valid_reg && m_nastilite.aw_ready;
  assign w_hs   = w_valid_reg  && m_nastilite.w_ready;
  assign b_hs   = b_ready_reg  && m_nastilite.b_valid;
  assign ar_hs  = ar_valid_reg && m_nastilite.ar_ready;
  assign r_hs   = r_ready_reg  && m_nastilite.r_valid;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cmd_ready_next = cmd_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    timeout_next   = timeout_reg;
    aw_valid_next  = aw_valid_reg;
    w_valid_next   = w_valid_reg;
    ar_valid_next  = ar_valid_reg;
    b_ready_next   = b_ready_reg;
    r_ready_next   = r_ready_reg;
    aw_addr_next   = aw_addr_reg;
    w_data_next    = w_data_reg;
    w_strb_next    = w_strb_reg;
    ar_addr_next   = ar_addr_reg;

    // Progress watchdog: only bus-waiting states count. The counter parks at
    // its last value, so the stalled cycle that finds it there is the
    // C_TIMEOUT_CYCLES-th consecutive one and raises the sticky flag.
    if (state_reg != IDLE && state_reg != RSP) begin
      if (any_hs) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
        timeout_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    unique case (state_reg)
      IDLE: begin
        // cmd_ready is a flop, so the first IDLE cycle after reset is not ready.
        cmd_ready_next = 1'b1;
        if (cmd_valid && cmd_ready_reg) begin
          cmd_ready_next = 1'b0;
          timeout_next   = 1'b0;
          cnt_next       = '0;
          if (cmd_write) begin
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            aw_addr_next  = cmd_addr;
            w_data_next   = cmd_wdata;
            w_strb_next   = cmd_wstrb;
            state_next    = WR_REQ;
          end else begin
            ar_valid_next = 1'b1;
            ar_addr_next  = cmd_addr;
            state_next    = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // A channel whose valid already dropped counts as done, so AW and W
        // may complete in either order or together.
        if (aw_hs) aw_valid_next = 1'b0;
        if (w_hs)  w_valid_next  = 1'b0;
        if ((!aw_valid_reg || aw_hs) && (!w_valid_reg || w_hs)) begin
          b_ready_next = 1'b1;
          state_next   = WR_RESP;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          b_ready_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = nasti_resp_t'(m_nastilite.b_resp);
          state_next     = RSP;
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          ar_valid_next = 1'b0;
          r_ready_next  = 1'b1;
          state_next    = RD_RESP;
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          r_ready_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b0;
          rsp_rdata_next = m_nastilite.r_data;
          rsp_resp_next  = nasti_resp_t'(m_nastilite.r_resp);
          state_next     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge m_nastilite_clk or negedge m_nastilite_aresetn) begin
    if (!m_nastilite_aresetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= OKAY;
      timeout_reg   <= 1'b0;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      b_ready_reg   <= 1'b0;
      r_ready_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      ar_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
      timeout_reg   <= timeout_next;
      aw_valid_reg  <= aw_valid_next;
      w_valid_reg   <= w_valid_next;
      ar_valid_reg  <= ar_valid_next;
      b_ready_reg   <= b_ready_next;
      r_ready_reg   <= r_ready_next;
      aw_addr_reg   <= aw_addr_next;
      w_data_reg    <= w_data_next;
      w_strb_reg    <= w_strb_next;
      ar_addr_reg   <= ar_addr_next;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign timeout   = timeout_reg;

  assign m_nastilite.aw_valid = aw_valid_reg;
  assign m_nastilite.aw_addr  = aw_addr_reg;
  assign m_nastilite.w_valid  = w_valid_reg;
  assign m_nastilite.w_data   = w_data_reg;
  assign m_nastilite.w_strb   = w_strb_reg;
  assign m_nastilite.b_ready  = b_ready_reg;
  assign m_nastilite.ar_valid = ar_valid_reg;
  assign m_nastilite.ar_addr  = ar_addr_reg;
  assign m_nastilite.r_ready  = r_ready_reg;

endmodule

// File: tb/tb_nastilite_cfg_master.sv
// Directed + randomized bench for nastilite_cfg_master. The bench plays the
// cfg slave cycle by cycle (programmable ready/response delays) and predicts
// every response from the command history: a word-indexed register array for
// read data, and a consecutive-stall count for the timeout flag.
module tb_nastilite_cfg_master;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  nastilite_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) nif ();

  nastilite_cfg_master #(
    .C_NASTI_ADDR_WIDTH(5),
    .C_NASTI_DATA_WIDTH(64),
    .C_TIMEOUT_CYCLES  (TMO)
  ) dut (
    .m_nastilite_clk    (clk),
    .m_nastilite_aresetn(rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .cmd_wstrb          (cmd_wstrb),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_write          (rsp_write),
    .rsp_rdata          (rsp_rdata),
    .rsp_resp           (rsp_resp),
    .timeout            (timeout),
    .m_nastilite        (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [63:0] slave_mem [4];   // what the bench slave actually stores
  logic [63:0] model_mem [4];   // what the command history says it should hold
  bit          tmo_exp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    nif.aw_ready = 1'b0;
    nif.w_ready  = 1'b0;
    nif.b_valid  = 1'b0;
    nif.b_resp   = 2'b00;
    nif.ar_ready = 1'b0;
    nif.r_valid  = 1'b0;
    nif.r_data   = '0;
    nif.r_resp   = 2'b00;
  endtask

  // One complete command. dly_a: AW (or AR) ready delay, dly_b: W ready delay,
  // resp_dly: cycles before B/R valid, rsp_dly: cycles of rsp_ready=0.
  task automatic do_cmd(input bit wr, input logic [4:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input int dly_a, input int dly_b,
                        input int resp_dly, input logic [1:0] sresp, input int rsp_dly,
                        input string tag);
    logic [63:0] exp_data, mask, wd_cap;
    logic [4:0]  aw_cap, ar_cap;
    logic [7:0]  ws_cap;
    bit aw_done, w_done, req_done, resp_done, fin, fin_next, hs, prev_bready, active;
    int a_seen, w_seen, resp_wait, rsp_wait, run, bphases, arv, rsp_first, n;
    aw_done = 0; w_done = 0; req_done = 0; resp_done = 0; fin = 0; fin_next = 0;
    prev_bready = 0; a_seen = 0; w_seen = 0; resp_wait = 0; rsp_wait = 0; run = 0;
    bphases = 0; arv = 0; rsp_first = 0; aw_cap = '0; ar_cap = '0; wd_cap = '0; ws_cap = '0;

    check({tag, ".idle_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, ".idle_timeout"}, timeout, tmo_exp);

    exp_data = wr ? 64'd0 : model_mem[addr[4:3]];
    if (wr) begin
      mask = '0;
      for (int b = 0; b < 8; b++) if (strb[b]) mask = mask | (64'hFF << (8 * b));
      model_mem[addr[4:3]] = (model_mem[addr[4:3]] & ~mask) | (data & mask);
    end

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    tick();
    // scramble the command inputs: the DUT must work from its own copy
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 5'($urandom);
    cmd_wdata = {$urandom, $urandom}; cmd_wstrb = 8'($urandom);
    tmo_exp = 1'b0;

    n = 1;
    while (!fin && n <= 300) begin
      slave_idle();
      rsp_ready = 1'b0;
      hs = 1'b0;
      active = !(req_done && resp_done);
      check({tag, ".timeout"}, timeout, tmo_exp);
      if (nif.b_ready && !prev_bready) bphases++;
      prev_bready = nif.b_ready;

      if (!req_done) begin
        check({tag, ".req_rsp_valid"}, rsp_valid, 1'b0);
        if (wr) begin
          check({tag, ".req_b_ready"}, nif.b_ready, 1'b0);
          if (!aw_done) begin
            check({tag, ".aw_valid"}, nif.aw_valid, 1'b1);
            check({tag, ".aw_addr"}, nif.aw_addr, addr);
            nif.aw_ready = (a_seen >= dly_a);
            a_seen++;
          end else check({tag, ".aw_valid_drop"}, nif.aw_valid, 1'b0);
          if (!w_done) begin
            check({tag, ".w_valid"}, nif.w_valid, 1'b1);
            check({tag, ".w_data"}, nif.w_data, data);
            check({tag, ".w_strb"}, nif.w_strb, strb);
            nif.w_ready = (w_seen >= dly_b);
            w_seen++;
          end else check({tag, ".w_valid_drop"}, nif.w_valid, 1'b0);
          if (nif.aw_valid && nif.aw_ready) begin aw_done = 1; aw_cap = nif.aw_addr; hs = 1; end
          if (nif.w_valid && nif.w_ready) begin
            w_done = 1; wd_cap = nif.w_data; ws_cap = nif.w_strb; hs = 1;
          end
          if (aw_done && w_done) begin
            req_done = 1;
            for (int b = 0; b < 8; b++)
              if (ws_cap[b]) slave_mem[aw_cap[4:3]][8*b +: 8] = wd_cap[8*b +: 8];
          end
        end else begin
          check({tag, ".ar_valid"}, nif.ar_valid, 1'b1);
          check({tag, ".ar_addr"}, nif.ar_addr, addr);
          check({tag, ".req_r_ready"}, nif.r_ready, 1'b0);
          arv++;
          nif.ar_ready = (a_seen >= dly_a);
          a_seen++;
          if (nif.ar_valid && nif.ar_ready) begin ar_cap = nif.ar_addr; req_done = 1; hs = 1; end
        end
      end else if (!resp_done) begin
        check({tag, ".resp_rsp_valid"}, rsp_valid, 1'b0);
        if (wr) begin
          check({tag, ".b_ready"}, nif.b_ready, 1'b1);
          check({tag, ".resp_aw_valid"}, nif.aw_valid, 1'b0);
          check({tag, ".resp_w_valid"}, nif.w_valid, 1'b0);
          if (resp_wait >= resp_dly) begin nif.b_valid = 1'b1; nif.b_resp = sresp; end
          if (nif.b_valid && nif.b_ready) begin resp_done = 1; hs = 1; end
        end else begin
          check({tag, ".r_ready"}, nif.r_ready, 1'b1);
          check({tag, ".resp_ar_valid"}, nif.ar_valid, 1'b0);
          if (resp_wait >= resp_dly) begin
            nif.r_valid = 1'b1; nif.r_data = slave_mem[ar_cap[4:3]]; nif.r_resp = sresp;
          end
          if (nif.r_valid && nif.r_ready) begin resp_done = 1; hs = 1; end
        end
        resp_wait++;
      end else begin
        if (rsp_first == 0) rsp_first = n;
        check({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        check({tag, ".rsp_write"}, rsp_write, wr);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_data);
        check({tag, ".rsp_resp"}, rsp_resp, sresp);
        check({tag, ".rsp_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, ".rsp_b_ready"}, nif.b_ready, 1'b0);
        check({tag, ".rsp_r_ready"}, nif.r_ready, 1'b0);
        if (rsp_wait >= rsp_dly) begin rsp_ready = 1'b1; fin_next = 1; end
        rsp_wait++;
      end

      if (active) begin
        run = hs ? 0 : run + 1;
        if (run >= TMO) tmo_exp = 1'b1;
      end
      tick();
      fin = fin_next;
      n++;
    end
    slave_idle();
    rsp_ready = 1'b0;

    check({tag, ".completed_in_budget"}, fin, 1'b1);
    check({tag, ".after_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, ".after_cmd_ready"}, cmd_ready, 1'b1);
    if (wr) check({tag, ".b_ready_phases"}, bphases, 1);
    else    check({tag, ".ar_valid_cycles"}, arv, dly_a + 1);
    // zero-wait: accept, request, response, rsp -> rsp_valid in the 4th cycle
    // counting the accept cycle as the first
    if (dly_a == 0 && dly_b == 0 && resp_dly == 0)
      check({tag, ".latency"}, rsp_first, 3);
    $display("txn %s wr=%0d addr=0x%0h data=0x%0h strb=0x%0h resp=%0d cycles=%0d timeout=%0d",
             tag, wr, addr, wr ? data : exp_data, strb, sresp, n - 1, tmo_exp);
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    slave_idle();
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      slave_mem[i] = v;
      model_mem[i] = v;
    end

    // reset state
    tick();
    tick();
    check("reset.cmd_ready", cmd_ready, 1'b0);
    check("reset.rsp_valid", rsp_valid, 1'b0);
    check("reset.rsp_write", rsp_write, 1'b0);
    check("reset.rsp_rdata", rsp_rdata, 64'd0);
    check("reset.rsp_resp", rsp_resp, 2'b00);
    check("reset.timeout", timeout, 1'b0);
    check("reset.aw_valid", nif.aw_valid, 1'b0);
    check("reset.w_valid", nif.w_valid, 1'b0);
    check("reset.ar_valid", nif.ar_valid, 1'b0);
    check("reset.b_ready", nif.b_ready, 1'b0);
    check("reset.r_ready", nif.r_ready, 1'b0);
    check("reset.aw_addr", nif.aw_addr, 5'd0);
    check("reset.w_data", nif.w_data, 64'd0);
    check("reset.w_strb", nif.w_strb, 8'd0);
    check("reset.ar_addr", nif.ar_addr, 5'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset.cmd_ready", cmd_ready, 1'b1);

    // directed
    do_cmd(1'b1, 5'h08, 64'h3, 8'hFF, 0, 0, 0, 2'b00, 0, "wr_zero_wait");
    do_cmd(1'b0, 5'h08, 64'h0, 8'h00, 0, 0, 0, 2'b00, 0, "rd_back");
    do_cmd(1'b1, 5'h10, 64'hDEAD_BEEF_0123_4567, 8'h5A, 3, 5, 0, 2'b00, 0, "wr_split");
    do_cmd(1'b0, 5'h10, 64'h0, 8'h00, 0, 0, 1, 2'b10, 10, "rd_backpressure");
    do_cmd(1'b1, 5'h18, 64'hCAFE_F00D_AAAA_5555, 8'hF0, 0, 0, 20, 2'b11, 0, "wr_timeout");
    do_cmd(1'b0, 5'h1B, 64'h0, 8'h00, 0, 0, 0, 2'b01, 0, "rd_clears_timeout");

    // reset while AR is pending
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h08;
    tick();
    cmd_valid = 1'b0;
    check("rst_mid.ar_valid_before", nif.ar_valid, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.ar_valid", nif.ar_valid, 1'b0);
    check("rst_mid.rsp_valid", rsp_valid, 1'b0);
    check("rst_mid.cmd_ready", cmd_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tmo_exp = 1'b0;
    tick();
    check("rst_mid.cmd_ready_after", cmd_ready, 1'b1);
    check("rst_mid.no_rsp", rsp_valid, 1'b0);
    $display("txn rst_mid_read aborted, cmd_ready=%0d", cmd_ready);
    do_cmd(1'b0, 5'h08, 64'h0, 8'h00, 0, 0, 0, 2'b00, 0, "rd_after_reset");

    // randomized
    for (int t = 0; t < 40; t++) begin
      do_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
             $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
